// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the DMEM arbiter: memory geometry, FSM encodings and port ids.
package dmem_arbiter_pkg;

  localparam int unsigned DMEM_SIZE   = 32;
  localparam int unsigned ARB_PORTS   = 2;
  localparam int unsigned ARB_ADDR_W  = $clog2(DMEM_SIZE);
  localparam int unsigned ARB_DATA_W  = 32;
  localparam int unsigned ARB_STATE_W = 2;

  localparam logic [ARB_STATE_W-1:0] ARB_IDLE  = 2'd0;
  localparam logic [ARB_STATE_W-1:0] ARB_ISSUE = 2'd1;
  localparam logic [ARB_STATE_W-1:0] ARB_RESP  = 2'd2;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational two-input round-robin picker; on a tie the port that did not win last goes.
module dmem_rr_pick
  import dmem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic any,
  output logic winner
);

  always_comb begin
    any    = req0 | req1;
    winner = PORT0;
    if (req0 && req1) begin
      winner = ~last_gnt;
    end else if (req1) begin
      winner = PORT1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-port DMEM: grant, one memory command,
// and a registered read response per access.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ARB_ADDR_W,
  parameter int unsigned DATA_W = ARB_DATA_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [ARB_STATE_W-1:0] state_q;
  logic [ARB_STATE_W-1:0] state_d;
  logic                   last_gnt_q;
  logic                   lat_port_q;
  logic                   lat_we_q;

  logic                   any;
  logic                   winner;
  logic                   load;
  logic                   capture;
  logic                   sel_we;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_wdata;
  logic [ARB_PORTS-1:0]   gnt_d;

  dmem_rr_pick u_pick (
    .req0     (req0),
    .req1     (req1),
    .last_gnt (last_gnt_q),
    .any      (any),
    .winner   (winner)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the one-cycle load/capture strobes that drive the registers below.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    capture   = 1'b0;
    sel_we    = (winner == PORT1) ? we1    : we0;
    sel_addr  = (winner == PORT1) ? addr1  : addr0;
    sel_wdata = (winner == PORT1) ? wdata1 : wdata0;
    gnt_d     = '0;
    case (state_q)
      ARB_IDLE: begin
        if (any) begin
          state_d = ARB_ISSUE;
          load    = 1'b1;
        end
      end
      ARB_ISSUE: begin
        state_d = lat_we_q ? ARB_IDLE : ARB_RESP;
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
        capture = 1'b1;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
    gnt_d[0] = load & (winner == PORT0);
    gnt_d[1] = load & (winner == PORT1);
  end

  // Outputs are set on entry to ISSUE so they are visible during the ISSUE cycle itself.
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_gnt_q <= PORT1;
      lat_port_q <= PORT0;
      lat_we_q   <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      busy       <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      gnt0    <= gnt_d[0];
      gnt1    <= gnt_d[1];
      mem_en  <= load;
      mem_we  <= load & sel_we;
      busy    <= (state_d != ARB_IDLE);
      rvalid0 <= capture & (lat_port_q == PORT0);
      rvalid1 <= capture & (lat_port_q == PORT1);
      if (load) begin
        last_gnt_q <= winner;
        lat_port_q <= winner;
        lat_we_q   <= sel_we;
        mem_addr   <= sel_addr;
        mem_wdata  <= sel_wdata;
      end
      if (capture && (lat_port_q == PORT0)) begin
        rdata0 <= mem_rdata;
      end
      if (capture && (lat_port_q == PORT1)) begin
        rdata1 <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural single-port DMEM.
module tb_dmem_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          CLK;
  logic          RST;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, busy;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  typedef struct packed {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } gnt_exp_t;

  gnt_exp_t      gq[$];
  logic [DW-1:0] rq0[$];
  logic [DW-1:0] rq1[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int pend_cyc [2];

  logic [DW-1:0] mem [32];

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .busy      (busy),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Memory model: writes commit at the edge, reads return one cycle later; never reset.
  always @(posedge CLK) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT issues a command or a response.
  always @(negedge CLK) begin
    gnt_exp_t e;
    if (mem_en) begin
      if (gq.size() == 0) begin
        check("unexpected_mem_en", 32'(mem_en), 32'd0);
      end else begin
        e = gq.pop_front();
        check("gnt_port", 32'({gnt1, gnt0}), e.port ? 32'd2 : 32'd1);
        check("mem_we", 32'(mem_we), 32'(e.we));
        check("mem_addr", 32'(mem_addr), 32'(e.addr));
        if (e.we) check("mem_wdata", mem_wdata, e.wdata);
        else      pend_cyc[e.port] = cyc;
      end
    end else if (gnt0 || gnt1) begin
      check("gnt_without_mem_en", 32'({gnt1, gnt0}), 32'd0);
    end
    if (rvalid0 || rvalid1) check("rvalid_exclusive", 32'(rvalid0 & rvalid1), 32'd0);
    if (rvalid0) begin
      if (rq0.size() == 0) check("unexpected_rvalid0", 32'(rvalid0), 32'd0);
      else begin
        check("rdata0", rdata0, rq0.pop_front());
        check("rvalid0_latency", 32'(cyc - pend_cyc[0]), 32'd2);
      end
    end
    if (rvalid1) begin
      if (rq1.size() == 0) check("unexpected_rvalid1", 32'(rvalid1), 32'd0);
      else begin
        check("rdata1", rdata1, rq1.pop_front());
        check("rvalid1_latency", 32'(cyc - pend_cyc[1]), 32'd2);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    idle(2);
    RST = 1'b0;
  endtask

  // Raise a request, push its expectations and wait (bounded) for the grant.
  task automatic access(input logic port, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata,
                        input bit expect_resp, input int exp_lat, input bit drop);
    int       n;
    gnt_exp_t e;
    n = 0;
    e.port = port; e.we = we; e.addr = addr; e.wdata = wdata;
    gq.push_back(e);
    if (!we && expect_resp) begin
      if (port) rq1.push_back(exp_rdata);
      else      rq0.push_back(exp_rdata);
    end
    if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; end
    else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; end
    do begin
      @(posedge CLK); #1;
      n++;
    end while (!(port ? gnt1 : gnt0) && n < 20);
    check("gnt_latency", 32'(n), 32'(exp_lat));
    if (drop) begin
      if (port) req1 = 1'b0;
      else      req0 = 1'b0;
    end
  endtask

  initial begin
    int   gcyc [4];
    logic gport [4];
    int   ng;

    RST = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    pend_cyc[0] = 0; pend_cyc[1] = 0;
    idle(3);
    check("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
    check("rst_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    RST = 1'b0;

    // Port 0 write, then port 1 reads it back.
    access(1'b0, 1'b1, 5'd3, 32'h0000_1234, 32'd0, 1'b0, 1, 1'b1);
    check("busy_in_issue", 32'(busy), 32'd1);
    idle(1);
    check("busy_after_write", 32'(busy), 32'd0);
    check("mem3_written", mem[3], 32'h0000_1234);
    access(1'b1, 1'b0, 5'd3, 32'd0, 32'h0000_1234, 1'b1, 1, 1'b1);
    idle(3);
    check("rdata0_unchanged", rdata0, 32'd0);

    // Preload, reset, then both ports read continuously.
    access(1'b1, 1'b1, 5'd1, 32'h0000_00A1, 32'd0, 1'b0, 1, 1'b1);
    idle(1);
    access(1'b1, 1'b1, 5'd2, 32'h0000_00B2, 32'd0, 1'b0, 1, 1'b1);
    idle(1);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      gnt_exp_t e;
      e.port = 1'(i % 2); e.we = 1'b0; e.addr = (i % 2 == 0) ? 5'd1 : 5'd2; e.wdata = '0;
      gq.push_back(e);
    end
    rq0.push_back(32'h0000_00A1); rq0.push_back(32'h0000_00A1);
    rq1.push_back(32'h0000_00B2); rq1.push_back(32'h0000_00B2);
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd2;
    ng = 0;
    for (int t = 0; t < 40 && ng < 4; t++) begin
      @(posedge CLK); #1;
      if (gnt0 || gnt1) begin
        gport[ng] = gnt1;
        gcyc[ng]  = cyc;
        ng++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("alt_grant_count", 32'(ng), 32'd4);
    for (int i = 0; i < ng; i++) check("alt_grant_port", 32'(gport[i]), 32'(i % 2));
    for (int i = 1; i < ng; i++) check("alt_grant_period", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
    idle(3);

    // Back-to-back port 0 writes, req held across grants.
    for (int i = 0; i < 4; i++)
      access(1'b0, 1'b1, 5'(i), 32'(777 + i), 32'd0, 1'b0, (i == 0) ? 1 : 2, i == 3);
    idle(2);
    for (int i = 0; i < 4; i++) check("b2b_mem", mem[i], 32'(777 + i));

    // Reset during a write's ISSUE still commits.
    access(1'b1, 1'b1, 5'd5, 32'h0000_0055, 32'd0, 1'b0, 1, 1'b1);
    RST = 1'b1;
    idle(1);
    RST = 1'b0;
    check("rst_issue_write_commit", mem[5], 32'h0000_0055);
    check("rst_issue_idle", 32'(busy), 32'd0);

    // Reset during a read's RESP drops the response.
    access(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1, 1'b1);
    idle(1);
    check("busy_in_resp", 32'(busy), 32'd1);
    RST = 1'b1;
    idle(1);
    RST = 1'b0;
    check("rst_resp_busy", 32'(busy), 32'd0);
    check("rst_resp_no_rvalid", 32'(rvalid0), 32'd0);
    check("rst_resp_rdata0", rdata0, 32'd0);
    access(1'b1, 1'b0, 5'd1, 32'd0, 32'd778, 1'b1, 1, 1'b1);
    idle(3);

    // Port 0 request during port 1 ISSUE waits for the IDLE cycle carrying rvalid1.
    access(1'b1, 1'b0, 5'd2, 32'd0, 32'd779, 1'b1, 1, 1'b1);
    access(1'b0, 1'b0, 5'd3, 32'd0, 32'd780, 1'b1, 3, 1'b1);
    idle(4);
    check("final_rdata0", rdata0, 32'd780);
    check("final_rdata1", rdata1, 32'd779);

    check("gq_empty", 32'(gq.size()), 32'd0);
    check("rq0_empty", 32'(rq0.size()), 32'd0);
    check("rq1_empty", 32'(rq1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
